// File: rtl/uart_pkg.sv
// Shared UART constants, byte type and FIFO width helpers used by both the
// receive-side and transmit-side buffers.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_DEPTH  = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  function automatic int uart_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a full FIFO (count == depth) is representable.
  function automatic int uart_cnt_w(input int depth);
    return uart_ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer bus: receiver byte/done inputs, register-block pop/clear
// strobes and the status/interrupt outputs. timeout_irq exists only with RX_TIMEOUT_EN.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_DEPTH
);

  logic [DATA_W-1:0]            rx_data_in;
  logic                         rx_done_in;
  logic                         rd_en;
  logic                         overrun_clr;
  logic [DATA_W-1:0]            rd_data;
  logic                         empty;
  logic                         full;
  logic [uart_cnt_w(DEPTH)-1:0] count;
  logic                         overrun;
  logic                         level_irq;
`ifdef RX_TIMEOUT_EN
  logic                         timeout_irq;
`endif

  modport master (
    output rx_data_in, rx_done_in, rd_en, overrun_clr,
`ifdef RX_TIMEOUT_EN
    input  timeout_irq,
`endif
    input  rd_data, empty, full, count, overrun, level_irq
  );

  modport slave (
    input  rx_data_in, rx_done_in, rd_en, overrun_clr,
`ifdef RX_TIMEOUT_EN
    output timeout_irq,
`endif
    output rd_data, empty, full, count, overrun, level_irq
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array with one synchronous write port and one
// asynchronous read port; contents are intentionally not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_DEPTH,
  parameter int DATA_W = UART_DATA_W,
  localparam int AW    = uart_ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: done-edge capture into a first-word-fall-through FIFO
// with overrun, level and (with RX_TIMEOUT_EN defined) idle-timeout interrupts.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH          = UART_DEPTH,
  parameter int DATA_W         = UART_DATA_W,
  parameter int LEVEL_THRESH   = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_fifo_if.slave   bus
);

  localparam int PTR_W = uart_ptr_w(DEPTH);
  localparam int CNT_W = uart_cnt_w(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end
  if ((LEVEL_THRESH < 1) || (LEVEL_THRESH > DEPTH)) begin : g_bad_thresh
    $error("uart_rx_fifo: LEVEL_THRESH must be in 1..DEPTH");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_rx_fifo: TIMEOUT_CYCLES must be >= 2");
  end

  logic              done_q;
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, full_q, overrun_q, overrun_d, level_q;
  logic              push, pop, wr_en, drop;
  logic [DATA_W-1:0] mem_rdata;

  // Pointers carry a wrap bit above the address so their difference is the count.
  always_comb begin
    push      = bus.rx_done_in & ~done_q;
    pop       = bus.rd_en & ~empty_q;
    wr_en     = push & (~full_q | pop);
    drop      = push & full_q & ~pop;
    wr_ptr_d  = wr_ptr_q + {{(CNT_W-1){1'b0}}, wr_en};
    rd_ptr_d  = rd_ptr_q + {{(CNT_W-1){1'b0}}, pop};
    count_d   = wr_ptr_d - rd_ptr_d;
    overrun_d = drop | (overrun_q & ~bus.overrun_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      done_q    <= bus.rx_done_in;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == CNT_W'(DEPTH));
      overrun_q <= overrun_d;
      level_q   <= (count_d >= CNT_W'(LEVEL_THRESH));
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[PTR_W-1:0]),
    .wdata_i (bus.rx_data_in),
    .raddr_i (rd_ptr_q[PTR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  assign bus.rd_data   = empty_q ? '0 : mem_rdata;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.overrun   = overrun_q;
  assign bus.level_irq = level_q;

`ifdef RX_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [IDLE_W-1:0] idle_q;
  logic              timeout_q;

  // Counter saturates at TIMEOUT_CYCLES-1; the irq stays set until traffic resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (push || pop || empty_q) begin
        idle_q <= '0;
      end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_q <= 1'b1;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
      if (push || pop) timeout_q <= 1'b0;
    end
  end

  assign bus.timeout_irq = timeout_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued at stimulus time
// and a negedge monitor checks every real pop against the queue head.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  uart_byte_t exp_q[$];
  uart_byte_t mon_exp;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_W(8), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .DEPTH          (DEPTH),
    .DATA_W         (8),
    .LEVEL_THRESH   (8),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle that pops a non-empty FIFO must present the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.rd_en && !bus.empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got 0x%0h expected no data at %0t", bus.rd_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rd_data", 32'(bus.rd_data), 32'(mon_exp));
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input uart_byte_t b, input bit accepted);
    bus.rx_data_in = b;
    bus.rx_done_in = 1'b1;
    if (accepted) exp_q.push_back(b);
    @(posedge clk); #1;
    bus.rx_done_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pop_n(input int n);
    bus.rd_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic chk_status(input string tag, input int cnt, input bit emp, input bit ful,
                            input bit ovr, input bit lvl);
    chk({tag, ".count"},   32'(bus.count),     32'(cnt));
    chk({tag, ".empty"},   32'(bus.empty),     32'(emp));
    chk({tag, ".full"},    32'(bus.full),      32'(ful));
    chk({tag, ".overrun"}, 32'(bus.overrun),   32'(ovr));
    chk({tag, ".level"},   32'(bus.level_irq), 32'(lvl));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.rx_data_in = '0;
    bus.rx_done_in = 1'b0;
    bus.rd_en      = 1'b0;
    bus.overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_status("reset", 0, 1, 0, 0, 0);
    chk("reset.rd_data", 32'(bus.rd_data), 32'h0);
`ifdef RX_TIMEOUT_EN
    chk("reset.timeout", 32'(bus.timeout_irq), 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single byte with done held high for 20 cycles.
    bus.rx_data_in = 8'hA5;
    bus.rx_done_in = 1'b1;
    exp_q.push_back(8'hA5);
    repeat (20) @(posedge clk);
    #1;
    bus.rx_done_in = 1'b0;
    chk_status("single", 1, 0, 0, 0, 0);
    chk("single.rd_data", 32'(bus.rd_data), 32'hA5);
    pop_n(1);
    chk_status("single_pop", 0, 1, 0, 0, 0);
    chk("single_pop.rd_data", 32'(bus.rd_data), 32'h0);

    // Fill with 0x00..0x0F, level crossing at the 8th push.
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == 6) chk("fill7.level", 32'(bus.level_irq), 32'h0);
      if (i == 7) chk("fill8.level", 32'(bus.level_irq), 32'h1);
    end
    chk_status("fill", 16, 0, 1, 0, 1);
    pop_n(16);
    chk_status("drain", 0, 1, 0, 0, 0);

    // Second fill exercises pointer wrap.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b1);
    chk_status("refill", 16, 0, 1, 0, 1);

    // Overrun: dropped byte, then set-vs-clear priority.
    send_byte(8'hEE, 1'b0);
    chk_status("ovr", 16, 0, 1, 1, 1);
    bus.overrun_clr = 1'b1;
    bus.rx_data_in  = 8'hEF;
    bus.rx_done_in  = 1'b1;
    @(posedge clk); #1;
    bus.overrun_clr = 1'b0;
    bus.rx_done_in  = 1'b0;
    @(posedge clk); #1;
    chk_status("ovr_setclr", 16, 0, 1, 1, 1);
    bus.overrun_clr = 1'b1;
    @(posedge clk); #1;
    bus.overrun_clr = 1'b0;
    chk("ovr_clr", 32'(bus.overrun), 32'h0);
    bus.overrun_clr = 1'b1;
    bus.rx_data_in  = 8'hED;
    bus.rx_done_in  = 1'b1;
    @(posedge clk); #1;
    bus.overrun_clr = 1'b0;
    bus.rx_done_in  = 1'b0;
    chk("ovr_set_wins", 32'(bus.overrun), 32'h1);
    @(posedge clk); #1;
    bus.overrun_clr = 1'b1;
    @(posedge clk); #1;
    bus.overrun_clr = 1'b0;
    chk("ovr_clr2", 32'(bus.overrun), 32'h0);

    // Push and pop together while full.
    bus.rd_en      = 1'b1;
    bus.rx_data_in = 8'h5A;
    bus.rx_done_in = 1'b1;
    exp_q.push_back(8'h5A);
    @(posedge clk); #1;
    bus.rd_en      = 1'b0;
    bus.rx_done_in = 1'b0;
    @(posedge clk); #1;
    chk_status("full_pushpop", 16, 0, 1, 0, 1);
    pop_n(16);
    chk_status("drain2", 0, 1, 0, 0, 0);

    // Push and pop together while empty: pop ignored.
    bus.rd_en      = 1'b1;
    bus.rx_data_in = 8'h3C;
    bus.rx_done_in = 1'b1;
    exp_q.push_back(8'h3C);
    @(posedge clk); #1;
    bus.rd_en      = 1'b0;
    bus.rx_done_in = 1'b0;
    @(posedge clk); #1;
    chk_status("empty_pushpop", 1, 0, 0, 0, 0);
    chk("empty_pushpop.rd_data", 32'(bus.rd_data), 32'h3C);
    pop_n(1);
    chk("empty_pushpop.drain", 32'(bus.empty), 32'h1);

    // Asynchronous reset mid-operation, done held high across release.
    for (int i = 0; i < 5; i++) send_byte(8'(8'h61 + i), 1'b1);
    chk("pre_rst.count", 32'(bus.count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_status("async_rst", 0, 1, 0, 0, 0);
    chk("async_rst.rd_data", 32'(bus.rd_data), 32'h0);
    exp_q.delete();
    bus.rx_data_in = 8'h77;
    bus.rx_done_in = 1'b1;
    exp_q.push_back(8'h77);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_done_held.count", 32'(bus.count), 32'd1);
    bus.rx_done_in = 1'b0;
    pop_n(1);
    chk("rst_done_held.empty", 32'(bus.empty), 32'h1);

`ifdef RX_TIMEOUT_EN
    repeat (40) @(posedge clk);
    #1;
    chk("to_empty", 32'(bus.timeout_irq), 32'h0);
    send_byte(8'h99, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    chk("to_31", 32'(bus.timeout_irq), 32'h0);
    @(posedge clk); #1;
    chk("to_32", 32'(bus.timeout_irq), 32'h1);
    pop_n(1);
    chk("to_pop_clr", 32'(bus.timeout_irq), 32'h0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. Captures each completed byte on the rising edge of the receiver's done flag and stores it in a first-word-fall-through FIFO. Exposes status, overrun and level-interrupt signals to the APB register block. Single clock domain; the receiver's byte/done outputs are already synchronous to clk.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
DATA_W, 8, byte width; must match receiver data width
LEVEL_THRESH, 8, level_irq asserts when count >= this value; range 1..DEPTH
TIMEOUT_CYCLES, 4096, idle clk cycles before timeout_irq; used only with RX_TIMEOUT_EN

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx_data_in  input  DATA_W  byte from receiver, valid while rx_done_in high
rx_done_in  input  1  receiver done flag; level, may stay high for many cycles
rd_en  input  1  pop strobe from register block, one entry per high cycle
rd_data  output  DATA_W  head entry (FWFT); 0 when empty
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  $clog2(DEPTH)+1  entries held
overrun  output  1  sticky, byte dropped because FIFO full
overrun_clr  input  1  clears overrun
level_irq  output  1  count >= LEVEL_THRESH
timeout_irq  output  1  present only with RX_TIMEOUT_EN

Behaviour:
- Reset (async, rst_n low): wr/rd pointers 0, count 0, empty 1, full 0, overrun 0, level_irq 0, timeout_irq 0, done_q 0, rd_data 0. Storage array not reset.
- Push detect: done_q <= rx_done_in each cycle; push = rx_done_in & ~done_q. Exactly one push per done rising edge; a held-high done never re-pushes. If rx_done_in is already high when rst_n deasserts, that counts as an edge.
- Push: writes rx_data_in at wr_ptr on the same clk edge; visible on rd_data/count the next cycle (1-cycle write-to-read latency).
- Pop: rd_en & ~empty advances rd_ptr; rd_data shows the next entry the cycle after. rd_en while empty is ignored; no state change.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is derived from pointer difference with an extra wrap bit. full = (count == DEPTH); empty = (count == 0).
- Push and pop in the same cycle:
  - Not empty: both take effect; count unchanged. This applies when full too: no overrun, the pushed byte is stored.
  - Empty: pop ignored, push accepted; count becomes 1.
- Overrun: push while full without a valid pop drops the byte. Storage and pointers are unchanged and overrun is set. overrun_clr clears it next cycle. Simultaneous set and clear: set wins.
- level_irq: registered compare, updated from the next-state count; follows count exactly one cycle after the push/pop edge with no hysteresis.
- No internal FSM beyond edge detect; all outputs registered except rd_data (mux of storage at rd_ptr, forced 0 when empty).

Optional Feature:
RX_TIMEOUT_EN
- Defined:
  - Idle counter clears on push, on pop, or when empty; otherwise increments while FIFO is non-empty.
  - At TIMEOUT_CYCLES-1, timeout_irq sets (sticky) and the counter saturates.
  - timeout_irq clears on next push, pop, or reset.
- Not defined: port timeout_irq absent, no counter logic; TIMEOUT_CYCLES unused.

Decomposition:
- Shared package uart_pkg: DATA_W default constant, byte typedef, default DEPTH, $clog2-derived pointer/count width helpers.
- Natural sub-module: uart_fifo_mem (DEPTH x DATA_W register array, write port, async read port), so the transmit-side FIFO can reuse it.
- Edge detect, pointers, flags and timeout stay in uart_rx_fifo.

Test Plan:
- Reset then single byte: rx_data_in=0xA5, rx_done_in high for 20 cycles -> exactly one push; next cycle count=1, empty=0, rd_data=0xA5; rd_en 1 cycle -> count=0, empty=1, rd_data=0.
- Fill/order: 16 done pulses with bytes 0x00..0x0F -> full=1, count=16, level_irq=1 from the 8th push onward; 16 pops return 0x00..0x0F in order; pointers wrap cleanly on a second fill.
- Overrun: FIFO full, pulse done with 0xEE -> overrun=1, count stays 16, 0xEE never read. overrun_clr and a new full-push in the same cycle -> overrun stays 1.
- Simultaneous push+pop: full with rd_en and done edge together -> count 16, overrun 0, new byte is the last read. Empty with both -> count 1.
- Reset mid-operation: count=5, assert rst_n low asynchronously between clk edges -> outputs at reset values immediately; done held high across deassert -> one push.
- RX_TIMEOUT_EN, TIMEOUT_CYCLES=32: one push, then idle -> timeout_irq high exactly 32 cycles after the push; pop clears it. With FIFO empty it never asserts.
